// File: rtl/tbird_pkg.sv
// Shared types and constants for the Thunderbird tail-light request controller.
//   mode_t       : active request mode (NONE, LEFT, RIGHT, HAZ), encoded 0..3
//   ctrl_state_t : controller states (IDLE, ISSUE, RUN, GAP)
//   LEFT_BANK    : mask of the left-bank light bits (LC, LB, LA)
//   RIGHT_BANK   : mask of the right-bank light bits (RA, RB, RC)
package tbird_pkg;

    typedef enum logic [1:0] {
        MODE_NONE  = 2'd0,
        MODE_LEFT  = 2'd1,
        MODE_RIGHT = 2'd2,
        MODE_HAZ   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_GAP   = 2'd3
    } ctrl_state_t;

    localparam logic [5:0] LEFT_BANK  = 6'b111000;
    localparam logic [5:0] RIGHT_BANK = 6'b000111;

endpackage

// File: rtl/tbird_signal_ctrl_sync2.sv
// Two-flop synchronizer for one asynchronous switch input.
//   clk   : clock
//   reset : asynchronous, active-high; clears both stages
//   d     : raw asynchronous input
//   q     : synchronized output (second stage)
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tbird_signal_ctrl.sv
// Request controller for the Thunderbird tail-light sequencer.
// Synchronizes the switches, arbitrates, issues one-clock start pulses to the
// light FSM, supervises each sequence through the light outputs and repeats
// sequences with a blanking gap while a request persists.
//   clk, reset          : clock, asynchronous active-high reset
//   left_sw/right_sw/hazard_sw : raw asynchronous switches
//   cancel              : synchronous; stop after the current sequence
//   lights[5:0]         : light FSM outputs, [5:3] left bank, [2:0] right bank
//   fsm_left/fsm_right  : start pulses to the light FSM
//   mode[1:0]           : active mode (0 NONE, 1 LEFT, 2 RIGHT, 3 HAZ)
//   busy                : controller not in IDLE
//   fault               : sticky sequence-fault flag
//
// state | meaning
// IDLE  | waiting for a request; mode shows NONE
// ISSUE | one clock, start pulse(s) driven to the light FSM
// RUN   | light FSM sequencing; watched for faults and completion
// GAP   | blanking clocks, then repeat / switch / stop decision
module tbird_signal_ctrl
    import tbird_pkg::*;
#(
    parameter int REPEAT  = 3,
    parameter int GAP     = 2,
    parameter int RUN_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_sw,
    input  logic       right_sw,
    input  logic       hazard_sw,
    input  logic       cancel,
    input  logic [5:0] lights,
    output logic       fsm_left,
    output logic       fsm_right,
    output logic [1:0] mode,
    output logic       busy,
    output logic       fault
);

    localparam int REP_W = $clog2(REPEAT + 1);
    localparam int RUN_W = $clog2(RUN_MAX + 1);
    localparam int GAP_W = $clog2(GAP + 1);

    logic l, r, h;

    sync2 u_sync_left   (.clk(clk), .reset(reset), .d(left_sw),   .q(l));
    sync2 u_sync_right  (.clk(clk), .reset(reset), .d(right_sw),  .q(r));
    sync2 u_sync_hazard (.clk(clk), .reset(reset), .d(hazard_sw), .q(h));

    ctrl_state_t state, state_n;
    mode_t       mode_q, mode_n, req;
    logic [REP_W-1:0] rep, rep_n;
    logic [RUN_W-1:0] runcnt, runcnt_n;
    logic [GAP_W-1:0] gapcnt, gapcnt_n;
    logic seen, seen_n, fault_n, cancel_pend, cancel_pend_n;
    logic bank_err;

    always_comb begin
        if (h || (l && r)) req = MODE_HAZ;
        else if (l)        req = MODE_LEFT;
        else if (r)        req = MODE_RIGHT;
        else               req = MODE_NONE;
    end

    // Wrong bank lit for the active mode, or hazard with one bank dark.
    always_comb begin
        bank_err = 1'b0;
        case (mode_q)
            MODE_LEFT:  bank_err = (lights & RIGHT_BANK) != 6'd0;
            MODE_RIGHT: bank_err = (lights & LEFT_BANK) != 6'd0;
            MODE_HAZ:   bank_err = (lights != 6'd0) &&
                                   (((lights & LEFT_BANK) == 6'd0) ||
                                    ((lights & RIGHT_BANK) == 6'd0));
            default:    bank_err = 1'b0;
        endcase
    end

    always_comb begin
        state_n  = state;
        mode_n   = mode_q;
        rep_n    = rep;
        runcnt_n = runcnt;
        gapcnt_n = gapcnt;
        seen_n   = seen;
        fault_n  = fault;
        case (state)
            ST_IDLE: begin
                mode_n = req;
                if (req != MODE_NONE) begin
                    rep_n   = REP_W'(REPEAT);
                    fault_n = 1'b0;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                runcnt_n = '0;
                seen_n   = 1'b0;
                state_n  = ST_RUN;
            end
            ST_RUN: begin
                runcnt_n = runcnt + RUN_W'(1);
                if (lights != 6'd0) seen_n = 1'b1;
                if (bank_err || (runcnt == '0 && lights == 6'd0)) begin
                    fault_n = 1'b1;
                    mode_n  = MODE_NONE;
                    state_n = ST_IDLE;
                end else if (seen && lights == 6'd0) begin
                    gapcnt_n = '0;
                    state_n  = ST_GAP;
                end else if (runcnt == RUN_W'(RUN_MAX - 1)) begin
                    fault_n = 1'b1;
                    mode_n  = MODE_NONE;
                    state_n = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gapcnt != GAP_W'(GAP - 1)) begin
                    gapcnt_n = gapcnt + GAP_W'(1);
                end else if (cancel_pend) begin
                    mode_n  = MODE_NONE;
                    state_n = ST_IDLE;
                end else if (req == MODE_HAZ && mode_q != MODE_HAZ) begin
                    mode_n  = MODE_HAZ;
                    rep_n   = REP_W'(REPEAT);
                    state_n = ST_ISSUE;
                end else if (rep > REP_W'(1)) begin
                    rep_n   = rep - REP_W'(1);
                    state_n = ST_ISSUE;
                end else if (req == mode_q) begin
                    rep_n   = REP_W'(REPEAT);
                    state_n = ST_ISSUE;
                end else begin
                    mode_n  = MODE_NONE;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                mode_n  = MODE_NONE;
                state_n = ST_IDLE;
            end
        endcase
    end

    // Cancel only latches outside IDLE and is dropped when IDLE is re-entered.
    always_comb begin
        cancel_pend_n = cancel_pend;
        if (state != ST_IDLE && state_n == ST_IDLE) cancel_pend_n = 1'b0;
        else if (state != ST_IDLE && cancel)        cancel_pend_n = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_NONE;
            rep         <= '0;
            runcnt      <= '0;
            gapcnt      <= '0;
            seen        <= 1'b0;
            fault       <= 1'b0;
            cancel_pend <= 1'b0;
        end else begin
            state       <= state_n;
            mode_q      <= mode_n;
            rep         <= rep_n;
            runcnt      <= runcnt_n;
            gapcnt      <= gapcnt_n;
            seen        <= seen_n;
            fault       <= fault_n;
            cancel_pend <= cancel_pend_n;
        end
    end

    assign fsm_left  = (state == ST_ISSUE) && (mode_q == MODE_LEFT  || mode_q == MODE_HAZ);
    assign fsm_right = (state == ST_ISSUE) && (mode_q == MODE_RIGHT || mode_q == MODE_HAZ);
    assign mode      = mode_q;
    assign busy      = (state != ST_IDLE);

endmodule

// File: doc/tbird_signal_ctrl.md
# tbird_signal_ctrl

Request controller for the Thunderbird tail-light sequencer. It synchronizes the raw left, right and hazard switches and arbitrates between them. It issues single-cycle start commands to the light FSM, then watches the FSM's six light outputs to track each sequence and detect faults. It repeats sequences with a blanking gap while a request persists, so the light FSM's inputs are never driven directly by switches.

## Interface
Parameters:
- REPEAT, 3: sequences issued per accepted request before the switch is re-checked (≥1).
- GAP, 2: idle clocks between sequences (≥1).
- RUN_MAX, 4: watchdog limit in clocks for one sequence.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- left_sw  in  1  raw left-turn switch, asynchronous.
- right_sw  in  1  raw right-turn switch, asynchronous.
- hazard_sw  in  1  raw hazard switch, asynchronous.
- cancel  in  1  synchronous; stop after the current sequence.
- lights  in  6  light FSM output; [5:3] is the left bank (LC, LB, LA), [2:0] is the right bank (RA, RB, RC).
- fsm_left  out  1  left start pulse to the light FSM.
- fsm_right  out  1  right start pulse to the light FSM.
- mode  out  2  active mode: 0 NONE, 1 LEFT, 2 RIGHT, 3 HAZ.
- busy  out  1  high in any state other than IDLE.
- fault  out  1  sticky sequence-fault flag.

## Operation
- All three switches pass through a 2-flop synchronizer; the synchronized values are `l`, `r` and `h`.
- Request priority: `h` or (`l` and `r`) gives HAZ; otherwise `l` gives LEFT; otherwise `r` gives RIGHT.
- The state machine has four states: IDLE, ISSUE, RUN and GAP.
- IDLE:
  - If a request is present: latch mode, load rep = REPEAT, clear fault, go to ISSUE.
  - Otherwise mode = NONE.
- ISSUE: lasts exactly one clock.
  - fsm_left = 1 when mode is LEFT or HAZ.
  - fsm_right = 1 when mode is RIGHT or HAZ.
  - Clear runcnt and the seen flag; go to RUN.
- RUN:
  - runcnt increments every clock.
  - seen is set when lights ≠ 0.
  - When seen and lights == 0: go to GAP with gapcnt = 0.
- Fault checks in RUN. Each check sets fault and sends the FSM to IDLE:
  - lights == 0 on the first RUN clock;
  - mode LEFT and lights[2:0] ≠ 0;
  - mode RIGHT and lights[5:3] ≠ 0;
  - mode HAZ and either bank is zero while lights ≠ 0;
  - runcnt reaches RUN_MAX.
- GAP: count GAP clocks, then evaluate in this order:
  - cancel_pend set: go to IDLE.
  - A request of strictly higher priority than the current mode (HAZ over LEFT or RIGHT): switch mode, reload rep, go to ISSUE.
  - rep > 1: decrement rep, go to ISSUE.
  - The same request is still present: reload rep, go to ISSUE.
  - Otherwise: go to IDLE.
- Cancel handling:
  - cancel in IDLE is ignored.
  - cancel in any other state sets cancel_pend, which is cleared on entry to IDLE.
  - A sequence already running is never truncated.
- Reset mid-sequence: the controller returns to IDLE immediately. The light FSM shares the reset, so it returns to S0 as well.

## Timing
- Reset values: state IDLE, fsm_left 0, fsm_right 0, mode 0, busy 0, fault 0, both synchronizer stages 0, cancel_pend 0.
- Switch-to-command latency: a switch set up before edge k produces fsm_* high for the clock following edge k+2.
- fsm_* are Moore outputs decoded from registered state and mode; they are glitch-free and exactly one clock wide.
- The light FSM leaves S0 on the edge that ends ISSUE. A healthy sequence therefore holds lights nonzero for 3 RUN clocks and spends 4 clocks in RUN.
- Period per sequence is 1 (ISSUE) + 4 (RUN) + GAP clocks, which is 7 clocks at the defaults.
- A switch released mid-sequence takes effect only at the GAP decision point.
- fault holds until the next request is accepted in IDLE, or until reset.

## Structure
- Package tbird_pkg holds:
  - mode_t enum (NONE, LEFT, RIGHT, HAZ);
  - ctrl_state_t enum (IDLE, ISSUE, RUN, GAP);
  - localparam masks LEFT_BANK = 6'b111000 and RIGHT_BANK = 6'b000111.
- Sub-module sync2: one instance per switch; a parameterless 2-flop synchronizer with asynchronous reset to 0.
- The controller top instantiates sync2 three times. It holds the arbiter, the state machine and the counters (rep, runcnt, gapcnt) sized with $clog2 of their parameters.

## Test plan
- Left held with the light FSM attached:
  - fsm_left pulses at edges 3, 10 and 17 (7-clock period).
  - lights step 001000, 011000, 111000; mode = 1; fault = 0.
- left_sw and right_sw raised on the same clock:
  - mode = 3 and both fsm_* pulse together.
  - lights show 001100, 011110, 111111.
- Right active, hazard raised mid-RUN: the next ISSUE runs in mode 3, not right, with rep reloaded to 3.
- cancel asserted in the second RUN clock:
  - the sequence completes with lights reaching 000111;
  - then GAP, then IDLE; busy falls and mode = 0.
- Fault injection: lights tied to 000000. Fault sets on the first RUN clock, the controller returns to IDLE, and fault clears on the next accepted request.
- reset asserted during RUN: all outputs are 0 within the same clock and the next ISSUE follows the normal 2-clock synchronizer latency.
